// File: rtl/spi_burst_memory.sv
// -----------------------------------------------------------------------------
// spi_burst_memory
//   SPI (mode 0, MSB first) slave front-end to an on-chip word memory with
//   auto-incrementing burst reads and writes. Every SPI pin is brought into the
//   clk domain through a 2-flop synchronizer; all state changes on clk only.
//
//   Frame format: {address MSB..LSB, rw} command (ADDR_WIDTH+1 bits), then any
//   number of DATA_WIDTH-bit data words. rw=1 reads, rw=0 writes; the address
//   increments (modulo depth) after every word.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   sclk_pin   SPI clock (asynchronous)
//   cs_pin     SPI chip select, active low (asynchronous)
//   mosi_pin   SPI master-out data (asynchronous)
//   miso_pin   SPI master-in data, high-Z unless miso_oe=1
//   miso_oe    high while miso_pin is driven
//   frame_err  sticky: last transaction ended with a partial frame
//   leds       debug {miso_oe, state[2:0]}
// -----------------------------------------------------------------------------
module spi_burst_memory #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic       miso_oe,
  output logic       frame_err,
  output logic [3:0] leds
);

  localparam int MAX_BITS = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  // Idle levels of {mosi, cs, sclk} held by the synchronizers during reset
  localparam logic [2:0] PIN_IDLE = 3'b010;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD       = 3'd1,
    RD_LOAD   = 3'd2,
    RD_SHIFT  = 3'd3,
    WR_SHIFT  = 3'd4,
    WR_COMMIT = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------------
  logic [2:0] pin_raw;
  logic [2:0] pin_sync;

  assign pin_raw = {mosi_pin, cs_pin, sclk_pin};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_q;
      logic sync_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_q <= PIN_IDLE[gi];
          sync_q <= PIN_IDLE[gi];
        end else begin
          meta_q <= pin_raw[gi];
          sync_q <= meta_q;
        end
      end
      assign pin_sync[gi] = sync_q;
    end
  endgenerate

  logic sclk_s, cs_hi, mosi_s;
  assign sclk_s = pin_sync[0];
  assign cs_hi  = pin_sync[1];
  assign mosi_s = pin_sync[2];

  // Edge detection against the previous synced sample: one-clk pulses
  logic sclk_prev_q, cs_prev_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_hi;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_hi & cs_prev_q;

  // After reset the synchronizers report the idle level before they have
  // sampled the real pin. If CS was already low, that looks like a fall; only
  // accept a CS fall once CS has genuinely been seen high after reset.
  logic [1:0] settle_q;
  logic       armed_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_q <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      settle_q <= {settle_q[0], 1'b1};
      if (settle_q[1] && cs_hi) armed_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t                  state_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   cmd_sr_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    miso_q;
  logic                    miso_oe_q;
  logic                    frame_err_q;

  logic cmd_last, data_last, wr_final_rise, abort;
  assign cmd_last      = (bit_cnt_q == CNT_W'(ADDR_WIDTH));
  assign data_last     = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign wr_final_rise = (state_q == WR_SHIFT) && sclk_rise && data_last;
  // A write frame completing on the same clk as CS rising still commits; the
  // CS rise is then seen one clk later in WR_COMMIT (CS is tested as a level).
  assign abort         = (state_q != IDLE) && cs_hi && !wr_final_rise;

  // Next address is needed combinationally so the memory read register can
  // already hold mem[addr] during the RD_LOAD cycle.
  always_comb begin
    addr_d = addr_q;
    case (state_q)
      CMD:       if (!cs_hi && sclk_rise && cmd_last) addr_d = cmd_sr_q;
      RD_SHIFT:  if (!cs_hi && sclk_rise && data_last) addr_d = addr_q + 1'b1;
      WR_COMMIT: addr_d = addr_q + 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      cmd_sr_q    <= '0;
      shreg_q     <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      if (abort) begin
        state_q   <= IDLE;
        miso_oe_q <= 1'b0;
        bit_cnt_q <= '0;
        if (bit_cnt_q != '0) frame_err_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            miso_oe_q <= 1'b0;
            if (cs_fall && armed_q) begin
              state_q     <= CMD;
              bit_cnt_q   <= '0;
              frame_err_q <= 1'b0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_sr_q <= (cmd_sr_q << 1) | ADDR_WIDTH'(mosi_s);
              if (cmd_last) begin
                // The bit arriving now is rw; cmd_sr_q already holds the address
                bit_cnt_q <= '0;
                state_q   <= mosi_s ? RD_LOAD : WR_SHIFT;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          RD_LOAD: begin
            shreg_q   <= rd_data_q;
            miso_oe_q <= 1'b1;
            state_q   <= RD_SHIFT;
          end
          RD_SHIFT: begin
            if (sclk_fall) begin
              miso_q  <= shreg_q[DATA_WIDTH-1];
              shreg_q <= shreg_q << 1;
            end
            if (sclk_rise) begin
              if (data_last) begin
                bit_cnt_q <= '0;
                state_q   <= RD_LOAD;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          WR_SHIFT: begin
            if (sclk_rise) begin
              shreg_q <= (shreg_q << 1) | DATA_WIDTH'(mosi_s);
              if (data_last) begin
                bit_cnt_q <= '0;
                state_q   <= WR_COMMIT;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          WR_COMMIT: begin
            state_q <= WR_SHIFT;
          end
          default: begin
            state_q   <= IDLE;
            miso_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word memory (never reset; contents persist across resets)
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;

  // Write strobe is derived from the state register, so an asynchronous reset
  // during WR_COMMIT suppresses the write immediately.
  assign mem_we = (state_q == WR_COMMIT);

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= shreg_q;
    rd_data_q <= mem[addr_d];
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign miso_pin  = miso_oe_q ? miso_q : 1'bz;
  assign miso_oe   = miso_oe_q;
  assign frame_err = frame_err_q;
  assign leds      = {miso_oe_q, state_q};

endmodule

// File: tb/tb_spi_burst_memory.sv
// -----------------------------------------------------------------------------
// tb_spi_burst_memory
//   Directed bench for spi_burst_memory. Two instances share sclk/mosi and the
//   reset, each with its own chip select: dut_a (7-bit address, 8-bit data)
//   and dut_b (4-bit address, 16-bit data). A bench-side memory model supplies
//   expected read words, queued when a read command is issued and popped as
//   each word is shifted out of the DUT.
// -----------------------------------------------------------------------------
module tb_spi_burst_memory;

  localparam int HALF = 8;  // SCLK half period in clk cycles

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       sclk  = 1'b0;
  logic       mosi  = 1'b0;
  logic       cs_a  = 1'b1;
  logic       cs_b  = 1'b1;
  wire        miso_a;
  wire        miso_b;
  logic       oe_a, oe_b, ferr_a, ferr_b;
  logic [3:0] leds_a, leds_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  mem_a[128];
  logic [15:0] mem_b[16];

  always #5 clk = ~clk;

  spi_burst_memory #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .sclk_pin(sclk), .cs_pin(cs_a), .mosi_pin(mosi),
    .miso_pin(miso_a), .miso_oe(oe_a), .frame_err(ferr_a), .leds(leds_a)
  );

  spi_burst_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .sclk_pin(sclk), .cs_pin(cs_b), .mosi_pin(mosi),
    .miso_pin(miso_b), .miso_oe(oe_b), .frame_err(ferr_b), .leds(leds_b)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cs(input int sel, input logic v);
    if (sel == 0) cs_a = v;
    else          cs_b = v;
  endtask

  function automatic logic get_miso(input int sel);
    return (sel == 0) ? miso_a : miso_b;
  endfunction

  // Mode 0 master: drive MOSI while SCLK low, sample MISO just before rise.
  task automatic spi_shift(input int sel, input int nbits, input logic [31:0] tx,
                           output logic [31:0] rx, input bit cs_on_last);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = tx[i];
      wait_clk(HALF);
      rx   = {rx[30:0], get_miso(sel)};
      sclk = 1'b1;
      if (cs_on_last && i == 0) set_cs(sel, 1'b1);
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_begin(input int sel);
    set_cs(sel, 1'b0);
    wait_clk(HALF);
  endtask

  task automatic cs_end(input int sel);
    wait_clk(HALF);
    set_cs(sel, 1'b1);
    wait_clk(2 * HALF);
  endtask

  task automatic send_cmd(input int sel, input int aw, input logic [31:0] addr, input logic rw);
    logic [31:0] cmd;
    logic [31:0] rx;
    cmd = (addr << 1) | {31'b0, rw};
    spi_shift(sel, aw + 1, cmd, rx, 1'b0);
  endtask

  task automatic send_word(input int sel, input int dw, input logic [31:0] data);
    logic [31:0] rx;
    spi_shift(sel, dw, data, rx, 1'b0);
  endtask

  task automatic recv_word(input int sel, input int dw, input string tag);
    logic [31:0] rx;
    logic [31:0] exp;
    spi_shift(sel, dw, 32'h0, rx, 1'b0);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
    check(tag, rx, exp);
  endtask

  initial begin
    logic [31:0] rx;

    // ---------------- reset state ----------------
    wait_clk(5);
    check("rst_oe_a", {31'b0, oe_a}, 32'd0);
    check("rst_ferr_a", {31'b0, ferr_a}, 32'd0);
    check("rst_led3_a", {31'b0, leds_a[3]}, 32'd0);
    check("rst_miso_a_undriven", {31'b0, miso_a === 1'b1}, 32'd0);
    check("rst_oe_b", {31'b0, oe_b}, 32'd0);
    check("rst_ferr_b", {31'b0, ferr_b}, 32'd0);
    reset = 1'b0;
    wait_clk(10);

    // ---------------- single write / read ----------------
    $display("[TB] A write addr=12 data=a5");
    cs_begin(0); send_cmd(0, 7, 32'h12, 1'b0); send_word(0, 8, 32'hA5); cs_end(0);
    mem_a[7'h12] = 8'hA5;
    check("wr12_ferr", {31'b0, ferr_a}, 32'd0);
    check("wr12_oe", {31'b0, oe_a}, 32'd0);

    $display("[TB] A read addr=12");
    exp_q.push_back({24'b0, mem_a[7'h12]});
    cs_begin(0); send_cmd(0, 7, 32'h12, 1'b1); recv_word(0, 8, "rd12_data");
    check("rd12_oe_active", {31'b0, oe_a}, 32'd1);
    check("rd12_led3_active", {31'b0, leds_a[3]}, 32'd1);
    cs_end(0);
    check("rd12_oe_after", {31'b0, oe_a}, 32'd0);
    check("rd12_miso_undriven", {31'b0, miso_a === 1'b1}, 32'd0);
    check("rd12_ferr", {31'b0, ferr_a}, 32'd0);

    // ---------------- burst write / read with wrap ----------------
    $display("[TB] A burst write addr=7f data=11,22,33");
    cs_begin(0); send_cmd(0, 7, 32'h7F, 1'b0);
    send_word(0, 8, 32'h11); send_word(0, 8, 32'h22); send_word(0, 8, 32'h33);
    cs_end(0);
    mem_a[7'h7F] = 8'h11; mem_a[7'h00] = 8'h22; mem_a[7'h01] = 8'h33;
    check("bwr_ferr", {31'b0, ferr_a}, 32'd0);

    $display("[TB] A burst read addr=7f x3");
    exp_q.push_back({24'b0, mem_a[7'h7F]});
    exp_q.push_back({24'b0, mem_a[7'h00]});
    exp_q.push_back({24'b0, mem_a[7'h01]});
    cs_begin(0); send_cmd(0, 7, 32'h7F, 1'b1);
    recv_word(0, 8, "brd_w0"); recv_word(0, 8, "brd_w1"); recv_word(0, 8, "brd_w2");
    cs_end(0);

    $display("[TB] A read addr=01");
    exp_q.push_back(32'h33);
    cs_begin(0); send_cmd(0, 7, 32'h01, 1'b1); recv_word(0, 8, "rd01_wrap"); cs_end(0);

    // ---------------- partial frame ----------------
    $display("[TB] A write addr=05 data=5a");
    cs_begin(0); send_cmd(0, 7, 32'h05, 1'b0); send_word(0, 8, 32'h5A); cs_end(0);
    mem_a[7'h05] = 8'h5A;

    $display("[TB] A partial write addr=05 5 bits");
    cs_begin(0); send_cmd(0, 7, 32'h05, 1'b0);
    spi_shift(0, 5, 32'h1F, rx, 1'b0);
    cs_end(0);
    check("partial_ferr_set", {31'b0, ferr_a}, 32'd1);

    $display("[TB] A cs toggle (no sclk)");
    cs_begin(0);
    check("cs_fall_clears_ferr", {31'b0, ferr_a}, 32'd0);
    cs_end(0);
    check("cs_toggle_ferr", {31'b0, ferr_a}, 32'd0);
    check("cs_toggle_oe", {31'b0, oe_a}, 32'd0);

    for (int k = 0; k < 3; k++) begin
      $display("[TB] A cs toggle %0d (no sclk)", k);
      cs_begin(0);
      check("idle_toggle_oe_low", {31'b0, oe_a}, 32'd0);
      cs_end(0);
      check("idle_toggle_ferr", {31'b0, ferr_a}, 32'd0);
    end

    $display("[TB] A read addr=05");
    exp_q.push_back({24'b0, mem_a[7'h05]});
    cs_begin(0); send_cmd(0, 7, 32'h05, 1'b1); recv_word(0, 8, "rd05_unchanged"); cs_end(0);

    // ---------------- CS rise together with final data rise ----------------
    $display("[TB] A write addr=30 data=c3, cs rises with last sclk rise");
    cs_begin(0); send_cmd(0, 7, 32'h30, 1'b0);
    spi_shift(0, 8, 32'hC3, rx, 1'b1);
    wait_clk(2 * HALF);
    mem_a[7'h30] = 8'hC3;
    check("cs_last_ferr", {31'b0, ferr_a}, 32'd0);
    check("cs_last_oe", {31'b0, oe_a}, 32'd0);

    $display("[TB] A read addr=30");
    exp_q.push_back({24'b0, mem_a[7'h30]});
    cs_begin(0); send_cmd(0, 7, 32'h30, 1'b1); recv_word(0, 8, "rd30_committed"); cs_end(0);

    // ---------------- reset mid-read ----------------
    $display("[TB] A read addr=12 interrupted by reset at bit 4");
    cs_begin(0); send_cmd(0, 7, 32'h12, 1'b1);
    spi_shift(0, 4, 32'h0, rx, 1'b0);
    check("pre_rst_oe", {31'b0, oe_a}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_oe", {31'b0, oe_a}, 32'd0);
    check("rst_mid_led3", {31'b0, leds_a[3]}, 32'd0);
    check("rst_mid_miso_undriven", {31'b0, miso_a === 1'b1}, 32'd0);
    wait_clk(4);
    reset = 1'b0;
    // CS still low: the block must not restart without a fresh CS fall
    spi_shift(0, 4, 32'hF, rx, 1'b0);
    check("post_rst_oe", {31'b0, oe_a}, 32'd0);
    set_cs(0, 1'b1);
    wait_clk(2 * HALF);

    $display("[TB] A read addr=12 after reset");
    exp_q.push_back({24'b0, mem_a[7'h12]});
    cs_begin(0); send_cmd(0, 7, 32'h12, 1'b1); recv_word(0, 8, "rd12_after_rst"); cs_end(0);
    check("rd12_after_rst_ferr", {31'b0, ferr_a}, 32'd0);

    // ---------------- 4-bit address / 16-bit data instance ----------------
    $display("[TB] B write addr=0 data=1234");
    cs_begin(1); send_cmd(1, 4, 32'h0, 1'b0); send_word(1, 16, 32'h1234); cs_end(1);
    mem_b[4'h0] = 16'h1234;

    $display("[TB] B write addr=f data=beef");
    cs_begin(1); send_cmd(1, 4, 32'hF, 1'b0); send_word(1, 16, 32'hBEEF); cs_end(1);
    mem_b[4'hF] = 16'hBEEF;
    check("b_wr_ferr", {31'b0, ferr_b}, 32'd0);

    $display("[TB] B burst read addr=f x2");
    exp_q.push_back({16'b0, mem_b[4'hF]});
    exp_q.push_back({16'b0, mem_b[4'h0]});
    cs_begin(1); send_cmd(1, 4, 32'hF, 1'b1);
    recv_word(1, 16, "b_rd_w0"); recv_word(1, 16, "b_rd_w1_wrap");
    cs_end(1);
    check("b_rd_oe_after", {31'b0, oe_b}, 32'd0);
    check("b_rd_ferr", {31'b0, ferr_b}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_burst_memory.md
SPI_BURST_MEMORY -- requirements
Module: spi_burst_memory

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, SHALL set the memory word-address width; depth = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the bits per memory word and per SPI data frame.
REQ-003 Port clk  input  1  FPGA system clock; all state SHALL change on its rising edge only.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port sclk_pin  input  1  SPI clock, asynchronous to clk.
REQ-006 Port cs_pin  input  1  SPI chip select, active low, asynchronous.
REQ-007 Port mosi_pin  input  1  SPI master-out data, asynchronous.
REQ-008 Port miso_pin  output  1  SPI master-in data; SHALL be high-impedance when miso_oe=0.
REQ-009 Port miso_oe  output  1  high while the block drives miso_pin.
REQ-010 Port frame_err  output  1  sticky flag: the last transaction ended mid-frame.
REQ-011 Port leds  output  4  debug: {miso_oe, state[2:0]}.

Function
REQ-012 Each pin input SHALL pass through a 2-flop synchronizer; a rise/fall pulse SHALL last exactly one clk when the synced value differs from its previous sample.
REQ-013 The block SHALL support SPI mode 0 only: sample MOSI on synced SCLK rise, update MISO on synced SCLK fall, MSB first.
REQ-014 SCLK high and low times SHALL each be at least 4 clk; behaviour below this is undefined.
REQ-015 The FSM SHALL use the states IDLE, CMD, RD_LOAD, RD_SHIFT, WR_SHIFT and WR_COMMIT.
REQ-016 IDLE: on synced CS fall the FSM SHALL go to CMD, clear the bit counter and clear frame_err.
REQ-017 CMD: the block SHALL shift in ADDR_WIDTH+1 bits, {address MSB..LSB, rw}; after the last bit it SHALL latch the address and go to RD_LOAD if rw=1, else WR_SHIFT.
REQ-018 RD_LOAD: the block SHALL read mem[addr] into the parallel-load shift register, assert miso_oe, then go to RD_SHIFT; this takes 1 clk.
REQ-019 RD_SHIFT: the current MSB SHALL appear on miso_pin at the first SCLK fall after load; each later fall SHALL shift one bit.
REQ-020 After DATA_WIDTH rises in RD_SHIFT, addr SHALL increment and the FSM SHALL return to RD_LOAD, so an unbounded burst read is possible.
REQ-021 WR_SHIFT: after DATA_WIDTH rises the FSM SHALL go to WR_COMMIT.
REQ-022 WR_COMMIT: the block SHALL write mem[addr] in 1 clk, increment addr, and return to WR_SHIFT.
REQ-023 Address increment SHALL wrap modulo 2**ADDR_WIDTH, so the address after all-ones is zero.
REQ-024 Synced CS rise in any non-IDLE state SHALL force IDLE within 1 clk and deassert miso_oe.
REQ-025 On a CS rise with a partial frame (bit counter nonzero), the block SHALL discard the partial word, perform no write, and set frame_err.
REQ-026 If a CS rise and the final SCLK rise of a write frame occur on the same clk, the write SHALL complete; CS handling SHALL take effect the following clk.
REQ-027 Memory contents SHALL not be reset and SHALL persist across transactions and resets.

Reset
REQ-028 While reset=1 the block SHALL hold: state=IDLE, miso_oe=0, miso_pin=Z, frame_err=0, counters=0, addr=0, and synchronizers at idle levels (cs=1, sclk=0).
REQ-029 A reset asserted mid-transaction SHALL abort it without any memory write; after release, the block SHALL wait for a fresh CS fall.

Verification
REQ-030 Write 0xA5 to addr 0x12 (cmd 0x24), then read addr 0x12 (cmd 0x25) -> MISO bits 1,0,1,0,0,1,0,1; frame_err=0.
REQ-031 Burst write 0x11,0x22,0x33 starting at addr 0x7F, then burst read from 0x7F -> 0x11, 0x22, 0x33 read from 0x7F, 0x00, 0x01 (wrap).
REQ-032 Write to addr 0x05 with 5 data bits then CS high -> mem[0x05] unchanged, frame_err=1; the next CS fall clears it.
REQ-033 Assert reset during bit 4 of a read -> miso_oe=0 and miso_pin=Z within 1 clk; state=IDLE; no memory change.
REQ-034 Instantiate with ADDR_WIDTH=4 and DATA_WIDTH=16, write 0xBEEF to addr 0xF, then burst read 2 words -> 0xBEEF followed by mem[0x0].
REQ-035 Between transactions miso_oe=0 throughout, and CS toggling with no SCLK edges -> no writes and frame_err=0.
